// File: rtl/ex_muldiv_ctrl_if.sv
// ex_muldiv_ctrl_if: EX-stage muldiv request/result bundle.
//   master (EX stage / bench): drives Start/Op/operands and mthi/mtlo writes.
//   slave  (ex_muldiv_ctrl)  : returns Busy/Done/Div0 and the HI/LO registers.
interface ex_muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic             Start_EX;
  logic [1:0]       Op_EX;
  logic [WIDTH-1:0] Operand_A_EX;
  logic [WIDTH-1:0] Operand_B_EX;
  logic             Write_HI_EX;
  logic             Write_LO_EX;
  logic [WIDTH-1:0] Write_Data_EX;
  logic             Busy_EX;
  logic             Done_EX;
  logic             Div0_EX;
  logic [WIDTH-1:0] HI_EX;
  logic [WIDTH-1:0] LO_EX;

  modport master (
    output Start_EX, Op_EX, Operand_A_EX, Operand_B_EX,
           Write_HI_EX, Write_LO_EX, Write_Data_EX,
    input  Busy_EX, Done_EX, Div0_EX, HI_EX, LO_EX
  );

  modport slave (
    input  Start_EX, Op_EX, Operand_A_EX, Operand_B_EX,
           Write_HI_EX, Write_LO_EX, Write_Data_EX,
    output Busy_EX, Done_EX, Div0_EX, HI_EX, LO_EX
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: radix-2 multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//   Clk, Reset : clock, synchronous active-high reset.
//   bus        : slave side of ex_muldiv_ctrl_if (request, mthi/mtlo, Busy/Done/Div0, HI/LO).
// The engine works on magnitudes; signs are re-applied in FIXUP. One shared
// {acc_hi, acc_lo} pair serves as product register (multiply) or
// remainder/quotient register (divide).
module ex_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  ex_muldiv_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic               neg_q;    // sign(A)^sign(B), signed ops only
  logic               sa_q;     // sign(A), signed ops only
  logic               div0_q;
  logic [WIDTH-1:0]   a_raw_q;  // original dividend, returned in HI on divide-by-zero
  logic [WIDTH-1:0]   m_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q, done_q, div0_out_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Start-time operand conditioning
  logic             s_signed, s_sa, s_sb;
  logic [WIDTH-1:0] s_mag_a, s_mag_b;
  assign s_signed = ~bus.Op_EX[0];
  assign s_sa     = s_signed & bus.Operand_A_EX[WIDTH-1];
  assign s_sb     = s_signed & bus.Operand_B_EX[WIDTH-1];
  assign s_mag_a  = s_sa ? -bus.Operand_A_EX : bus.Operand_A_EX;
  assign s_mag_b  = s_sb ? -bus.Operand_B_EX : bus.Operand_B_EX;

  // One iteration of shift-add (multiply) or restoring shift-subtract (divide)
  logic [WIDTH:0]   add_sum, rem_sh, diff;
  logic [WIDTH-1:0] hi_n, lo_n;
  assign add_sum = {1'b0, acc_hi} + {1'b0, {WIDTH{acc_lo[0]}} & m_q};
  assign rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, m_q};

  always_comb begin
    hi_n = acc_hi;
    lo_n = acc_lo;
    if (op_q[1]) begin
      // diff[WIDTH] set means the trial subtract borrowed: restore
      if (!diff[WIDTH]) begin
        hi_n = diff[WIDTH-1:0];
        lo_n = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = rem_sh[WIDTH-1:0];
        lo_n = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_n, lo_n} = {add_sum, acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIXUP
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               is_signed_q;
  assign is_signed_q = ~op_q[0];
  assign prod        = {acc_hi, acc_lo};
  assign prod_fix    = (is_signed_q && neg_q) ? -prod : prod;
  assign q_fix       = (is_signed_q && neg_q) ? -acc_lo : acc_lo;
  assign r_fix       = (is_signed_q && sa_q)  ? -acc_hi : acc_hi;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      op_q       <= '0;
      neg_q      <= 1'b0;
      sa_q       <= 1'b0;
      div0_q     <= 1'b0;
      a_raw_q    <= '0;
      m_q        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div0_out_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      div0_out_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          // mthi/mtlo land even alongside a start; the result overwrites later
          if (bus.Write_HI_EX) hi_q <= bus.Write_Data_EX;
          if (bus.Write_LO_EX) lo_q <= bus.Write_Data_EX;
          if (bus.Start_EX) begin
            op_q    <= bus.Op_EX;
            neg_q   <= s_sa ^ s_sb;
            sa_q    <= s_sa;
            a_raw_q <= bus.Operand_A_EX;
            div0_q  <= bus.Op_EX[1] && (bus.Operand_B_EX == '0);
            acc_hi  <= '0;
            if (bus.Op_EX[1]) begin
              m_q    <= s_mag_b;
              acc_lo <= s_mag_a;
            end else begin
              m_q    <= s_mag_a;
              acc_lo <= s_mag_b;
            end
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          acc_hi <= hi_n;
          acc_lo <= lo_n;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= FIXUP;
        end
        FIXUP: begin
          if (op_q[1]) begin
            if (div0_q) begin
              hi_q <= a_raw_q;
              lo_q <= '1;
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          div0_out_q <= div0_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy_EX = busy_q;
  assign bus.Done_EX = done_q;
  assign bus.Div0_EX = div0_out_q;
  assign bus.HI_EX   = hi_q;
  assign bus.LO_EX   = lo_q;
endmodule
